mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised MEM pipeline stage for a latency-tolerant data memory. Sits between EX/MEM and MEM/WB.
//  - Issues loads/stores over a req/gnt + rvalid handshake.
//  - Stalls the pipeline until each access completes.
//  - Generates byte enables and shifted write data; sign/zero-extends load data.
//  - Registers all MEM/WB outputs.
// PARAMETERS
//  XLEN    32  datapath width, 32 or 64; byte lanes NB = XLEN/8
//  ADDR_W  32  dmem address width, <= XLEN
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high
//  in_valid       in   1       EX/MEM slot holds an instruction
//  in_mem_read    in   1       load
//  in_mem_write   in   1       store
//  in_funct3      in   3       access size/type
//  in_alu_result  in   XLEN    effective address / ALU result
//  in_write_data  in   XLEN    store data, unshifted
//  in_rd          in   5       destination register
//  in_reg_write   in   1       register-write control
//  in_result_src  in   2       result-select control
//  in_pcplus4     in   XLEN    PC+4
//  in_immext      in   XLEN    extended immediate
//  stall          out  1       hold IF..EX/MEM this cycle (combinational)
//  dmem_req       out  1       access request
//  dmem_we        out  1       1 = store
//  dmem_be        out  NB      byte enables
//  dmem_addr      out  ADDR_W  word-aligned address (low log2(NB) bits = 0)
//  dmem_wdata     out  XLEN    lane-shifted store data
//  dmem_gnt       in   1       request accepted this cycle
//  dmem_rvalid    in   1       load data valid
//  dmem_rdata     in   XLEN    load data, full word
//  wb_valid, wb_reg_write, wb_result_src, wb_rd, wb_alu_result, wb_load_data, wb_pcplus4, wb_immext
//                 out          registered MEM/WB copies; widths as inputs, wb_load_data XLEN
//  wb_misalign    out  1       misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  - mem_op = in_valid & (in_mem_read | in_mem_write). Upstream holds all in_* stable while stall=1.
//  - FSM state IDLE:
//    - dmem_req = mem_op. dmem_we = in_mem_write.
//    - Store with gnt: done this cycle, stay IDLE.
//    - Load with gnt: go to RSP.
//    - No gnt: hold req and all dmem_* stable, stay IDLE.
//  - FSM state RSP:
//    - dmem_req = 0.
//    - dmem_rvalid: load done, go to IDLE. Otherwise wait (no timeout).
//    - dmem_rvalid is sampled only in RSP, so memory latency >= 1 cycle after gnt.
//  - stall = mem_op & ~done. On the done cycle stall = 0 and the pipeline advances.
//  - Non-memory instructions never stall; they reach WB the next cycle.
//  - WB register load:
//    - Loads when stall = 0: wb_valid <= in_valid; other wb_* <= in_*.
//    - Loads when stall = 1: wb_valid <= 0 (bubble); wb_reg_write <= 0.
//  - Minimum latencies:
//    - Store with gnt in the same cycle: 0 stall cycles.
//    - Load: (gnt wait) + 1 + (rvalid wait) stall cycles.
//  - Lane index o = in_alu_result[log2(NB)-1:0].
//  - Byte enables: base mask by size (b=1, h=3, w=0xF, d=0xFF), shifted left by o, truncated to NB.
//  - dmem_wdata = in_write_data << (8*o).
//  - funct3 decode:
//    - 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu: sign- or zero-extend from dmem_rdata >> (8*o).
//    - 110 lwu: zero-extend; XLEN=64 only.
//    - 011 ld/sd: XLEN=64 only. At XLEN=32, 011 is treated as 010 and 110 as 100.
//  - Capture of wb_load_data:
//    - Loads: captured at rvalid from dmem_rdata; the o used is the held in_alu_result.
//    - Stores and non-memory instructions: wb_load_data <= 0.
//  - Reset:
//    - state = IDLE; dmem_req = 0; stall = 0 while reset.
//    - Every wb_* register = 0.
//    - A pending load is abandoned; a later stray rvalid in IDLE is ignored.
//  - in_mem_read & in_mem_write both set: treated as store.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//    - A misaligned access is one whose size does not divide its address.
//    - On such an access: no dmem_req, stall = 0.
//    - Next cycle: wb_valid = 1, wb_reg_write = 0, wb_misalign = 1 for 1 cycle.
//    - wb_alu_result holds the faulting address.
//  MEM_MISALIGN_TRAP_EN undefined:
//    - The access is issued with a truncated mask; lanes crossing the word are dropped.
//    - wb_misalign tied 0.
// TESTING (XLEN=32)
//  1. sw 0xDEADBEEF @0x100, gnt same cycle -> be=0xF, wdata=0xDEADBEEF, addr=0x100, stall=0; next cycle wb_valid=1.
//  2. sb 0x000000AB @0x103, gnt after 2 cycles -> be=0x8, wdata=0xAB000000; stall=1 for 2 cycles; wb bubbles then wb_valid=1.
//  3. lb @0x102, gnt 1 cycle late, rvalid 3 cycles after gnt, rdata=0x1280FF00 -> wb_load_data=0xFFFFFF80; stall high 4 cycles.
//  4. lhu @0x102, rdata=0x8001_1234 -> wb_load_data=0x00008001; lh same data -> 0xFFFF8001.
//  5. Load granted, reset in RSP, rvalid 2 cycles later -> dmem_req=0, wb_* all 0, stall=0; stray rvalid ignored.
//  6. MEM_MISALIGN_TRAP_EN, lw @0x101 -> no dmem_req, stall=0, wb_misalign=1, wb_reg_write=0, wb_alu_result=0x101.

Source files
------------

// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: data-memory req/gnt + rvalid bus between the MEM stage (master) and memory (slave)
interface mem_stage_hs_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [XLEN/8-1:0] be;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: stalling MEM stage over a req/gnt + rvalid dmem bus; define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
module mem_stage_hs #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_write_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_result_src,
  input  logic [XLEN-1:0]   in_pcplus4,
  input  logic [XLEN-1:0]   in_immext,
  output logic              stall,
  mem_stage_hs_if.master    dmem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [1:0]        wb_result_src,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_alu_result,
  output logic [XLEN-1:0]   wb_load_data,
  output logic [XLEN-1:0]   wb_pcplus4,
  output logic [XLEN-1:0]   wb_immext,
  output logic              wb_misalign
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int SW = $clog2(XLEN) + 1;
  typedef enum logic {IDLE, RSP} state_t;
  state_t st, nxt;
  logic [OB-1:0] o;
  logic [1:0] sz;
  logic u, mem_op, mis, issue, done;
  logic [7:0] base;
  logic [XLEN-1:0] sh, lj, ext;
  logic signed [XLEN-1:0] sx;
  logic [SW-1:0] sft;
  assign o = in_alu_result[OB-1:0];
  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign issue = mem_op & ~mis;
`ifdef MEM_MISALIGN_TRAP_EN
  logic [OB-1:0] lm;
  assign lm = OB'((OB'(1) << sz) - 1);
  assign mis = mem_op & |(o & lm);
  always_ff @(posedge clk) wb_misalign <= ~reset & mis;
`else
  assign mis = 1'b0;
  assign wb_misalign = 1'b0;
`endif
  always_comb begin
    sz = (XLEN == 32 && in_funct3[1:0] == 2'b11) ? 2'd2 :
         (XLEN == 32 && in_funct3 == 3'b110) ? 2'd0 : in_funct3[1:0];
    u = in_funct3[2];
    base = (sz == 2'd0) ? 8'h01 : (sz == 2'd1) ? 8'h03 : (sz == 2'd2) ? 8'h0F : 8'hFF;
    dmem.be = NB'(base) << o;
    dmem.wdata = in_write_data << {o, 3'b000};
    dmem.addr = {in_alu_result[ADDR_W-1:OB], OB'(0)};
    dmem.we = in_mem_write;
    sh = dmem.rdata >> {o, 3'b000};
    sft = SW'(XLEN - (8 << sz));
    lj = sh << sft;
    sx = $signed(lj) >>> sft;
    ext = u ? (lj >> sft) : sx;
  end
  always_ff @(posedge clk) st <= reset ? IDLE : nxt;
  always_comb begin
    dmem.req = ~reset & (st == IDLE) & issue;
    done = (st == IDLE) ? (issue & in_mem_write & dmem.gnt) : dmem.rvalid;
    nxt = (st == IDLE) ? ((issue & ~in_mem_write & dmem.gnt) ? RSP : IDLE) : (dmem.rvalid ? IDLE : RSP);
    stall = ~reset & issue & ~done;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_result_src <= '0;
      wb_rd <= '0;
      wb_alu_result <= '0;
      wb_load_data <= '0;
      wb_pcplus4 <= '0;
      wb_immext <= '0;
    end else if (stall) begin
      wb_valid <= 1'b0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid <= in_valid;
      wb_reg_write <= in_reg_write & ~mis;
      wb_result_src <= in_result_src;
      wb_rd <= in_rd;
      wb_alu_result <= in_alu_result;
      wb_load_data <= (issue & ~in_mem_write) ? ext : '0;
      wb_pcplus4 <= in_pcplus4;
      wb_immext <= in_immext;
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed and randomized checks of mem_stage_hs at XLEN=32 against a byte-level model
module tb_mem_stage_hs;
  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [2:0] in_funct3;
  logic [31:0] in_alu_result, in_write_data, in_pcplus4, in_immext;
  logic [4:0] in_rd;
  logic [1:0] in_result_src;
  logic stall, wb_valid, wb_reg_write, wb_misalign;
  logic [1:0] wb_result_src;
  logic [4:0] wb_rd;
  logic [31:0] wb_alu_result, wb_load_data, wb_pcplus4, wb_immext;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_stage_hs_if #(.XLEN(32), .ADDR_W(32)) dmem ();
  mem_stage_hs #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_write_data(in_write_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_result_src(in_result_src), .in_pcplus4(in_pcplus4), .in_immext(in_immext),
    .stall(stall), .dmem(dmem), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_result_src(wb_result_src), .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
    .wb_load_data(wb_load_data), .wb_pcplus4(wb_pcplus4), .wb_immext(wb_immext),
    .wb_misalign(wb_misalign)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int nbytes(input logic [2:0] f3);
    return (f3 == 3'b110 || f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) b[i] = (i >= int'(a[1:0])) && (i < int'(a[1:0]) + nbytes(f3));
    return b;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [31:0] a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) if (i >= int'(a[1:0])) w[8*i +: 8] = wd[8*(i-int'(a[1:0])) +: 8];
    return w;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v = 0;
    int n = nbytes(f3);
    int o = int'(a[1:0]);
    for (int k = 0; k < n; k++) if (o + k < 4) v += longint'(rd[8*(o+k) +: 8]) << (8*k);
    if (!f3[2] && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rdat, input int g, input int r);
    logic mop = rd | wr;
    logic ld = rd & ~wr;
    int total = !mop ? 0 : (wr ? g : g + r);
    logic [4:0] rdx = 5'($urandom);
    logic rw = 1'($urandom);
    logic [1:0] rs = 2'($urandom);
    logic [31:0] pc = $urandom;
    logic [31:0] im = $urandom;
    in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_funct3 = f3;
    in_alu_result = a; in_write_data = wd; in_rd = rdx; in_reg_write = rw;
    in_result_src = rs; in_pcplus4 = pc; in_immext = im; dmem.rdata = rdat;
    for (int c = 0; c <= total; c++) begin
      dmem.gnt = mop && c == g;
      dmem.rvalid = ld && c == g + r;
      @(negedge clk);
      chk("stall", 32'(stall), 32'(c < total));
      chk("req", 32'(dmem.req), 32'(mop && c <= g));
      if (mop && c <= g) begin
        chk("be", 32'(dmem.be), 32'(m_be(f3, a)));
        chk("wdata", dmem.wdata, m_wdata(wd, a));
        chk("addr", dmem.addr, {a[31:2], 2'b00});
        chk("we", 32'(dmem.we), 32'(wr));
      end
      @(posedge clk); #1;
      if (c < total) begin
        chk("bubble_valid", 32'(wb_valid), 0);
        chk("bubble_rw", 32'(wb_reg_write), 0);
      end
    end
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    chk("wb_valid", 32'(wb_valid), 1);
    chk("wb_rd", 32'(wb_rd), 32'(rdx));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(rw));
    chk("wb_result_src", 32'(wb_result_src), 32'(rs));
    chk("wb_alu_result", wb_alu_result, a);
    chk("wb_load_data", wb_load_data, ld ? m_load(f3, a, rdat) : 32'h0);
    chk("wb_pcplus4", wb_pcplus4, pc);
    chk("wb_immext", wb_immext, im);
    chk("wb_misalign", 32'(wb_misalign), 0);
  endtask
  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_req", 32'(dmem.req), 0);
    @(posedge clk); #1;
    chk("idle_wb_valid", 32'(wb_valid), 0);
    chk("idle_wb_load", wb_load_data, 0);
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'b010;
    in_alu_result = 32'h40; in_write_data = 0; in_rd = 5'd3; in_reg_write = 1'b1; in_result_src = 2'd1;
    in_pcplus4 = 32'h4; in_immext = 32'h8; dmem.gnt = 1'b1; dmem.rvalid = 1'b0; dmem.rdata = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_req", 32'(dmem.req), 0);
      @(posedge clk); #1;
    end
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rw", 32'(wb_reg_write), 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_wb_pc", wb_pcplus4, 0);
    reset = 1'b0; dmem.gnt = 1'b0;
    idle();
    run(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    run(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 2, 1);
    run(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h1280FF00, 1, 3);
    run(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0, 1);
    run(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2, 2);
    run(1'b0, 1'b0, 3'b010, 32'h55, 32'h0, 32'h0, 0, 1);
    run(1'b1, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1, 1);
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'b010;
    in_alu_result = 32'h200; dmem.gnt = 1'b1; dmem.rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t5_req", 32'(dmem.req), 1);
    @(posedge clk); #1;
    dmem.gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_stall", 32'(stall), 0);
    chk("t5_rst_req", 32'(dmem.req), 0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("t5_wb_valid", 32'(wb_valid), 0);
    chk("t5_wb_alu", wb_alu_result, 0);
    chk("t5_wb_rd", 32'(wb_rd), 0);
    chk("t5_wb_load", wb_load_data, 0);
    dmem.rvalid = 1'b1;
    @(negedge clk);
    chk("t5_stray_stall", 32'(stall), 0);
    chk("t5_stray_req", 32'(dmem.req), 0);
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    chk("t5_stray_wb_valid", 32'(wb_valid), 0);
    chk("t5_stray_wb_load", wb_load_data, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'b010;
    in_alu_result = 32'h101; in_reg_write = 1'b1;
    @(negedge clk);
    chk("t6_req", 32'(dmem.req), 0);
    chk("t6_stall", 32'(stall), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_wb_valid", 32'(wb_valid), 1);
    chk("t6_wb_misalign", 32'(wb_misalign), 1);
    chk("t6_wb_rw", 32'(wb_reg_write), 0);
    chk("t6_wb_alu", wb_alu_result, 32'h101);
    @(posedge clk); #1;
    chk("t6_misalign_clear", 32'(wb_misalign), 0);
`endif
    for (int i = 0; i < 60; i++) begin
      int kind = int'($urandom_range(0, 2));
      logic [2:0] f3;
      logic [31:0] a = $urandom;
      logic [2:0] fl [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
      f3 = fl[$urandom_range(0, 6)];
`ifdef MEM_MISALIGN_TRAP_EN
      a = a & ~32'(nbytes(f3) - 1);
`endif
      if (kind == 0) run(1'b0, 1'b0, f3, a, $urandom, $urandom, 0, 1);
      else if (kind == 1) run(1'b1, 1'b0, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      else run(1'($urandom), 1'b1, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)), 1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
